bpsm_sequencer: RTL and testbench

BPSM_SEQUENCER -- requirements
Module: bpsm_sequencer

---
 rtl/bpsm_sequencer_if.sv | 32 +++
 rtl/bpsm_sequencer.sv | 149 ++++++++++++++
 tb/tb_bpsm_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bpsm_sequencer_if.sv
// Purpose: bundles the three handshakes of the pin sequencer: the command FIFO,
//          the SPI byte engine and the result FIFO.
// Ports (master = sequencer side):
//   cmd_data/cmd_nempty -> in, cmd_pop <- out   : first-word-fall-through input FIFO
//   spi_data/spi_start  <- out                  : byte and start strobe to SPI engine
//   spi_busy/spi_done/spi_rx -> in              : SPI engine status and received byte
//   res_data/res_push   <- out, res_full -> in  : result output FIFO
interface bpsm_sequencer_if #(
  parameter int unsigned FIFO_WIDTH = 16
);
  logic [FIFO_WIDTH-1:0] cmd_data;
  logic                  cmd_nempty;
  logic                  cmd_pop;
  logic [7:0]            spi_data;
  logic                  spi_start;
  logic                  spi_busy;
  logic                  spi_done;
  logic [7:0]            spi_rx;
  logic [FIFO_WIDTH-1:0] res_data;
  logic                  res_push;
  logic                  res_full;

  modport master (
    input  cmd_data, cmd_nempty, spi_busy, spi_done, spi_rx, res_full,
    output cmd_pop, spi_data, spi_start, res_data, res_push
  );

  modport slave (
    output cmd_data, cmd_nempty, spi_busy, spi_done, spi_rx, res_full,
    input  cmd_pop, spi_data, spi_start, res_data, res_push
  );
endinterface

// File: rtl/bpsm_sequencer.sv
// Purpose: command sequencer. Fetches 16-bit words (opcode[15:8], operand[7:0])
//          from a FWFT FIFO and executes pin writes, SPI transfers, delays and
//          logic-analyzer start/stop; SPI results go to an output FIFO.
// Ports:
//   clock, reset (async, active-low)
//   pause     : blocks fetching of new commands; rising edge clears error
//   bus       : command FIFO / SPI engine / result FIFO handshakes (master)
//   io_out    : registered pin levels
//   la_active : logic analyzer capture enable
//   active    : high in every state except IDLE
//   error     : sticky unknown-opcode flag
module bpsm_sequencer #(
  parameter int unsigned BP_PINS        = 5,
  parameter int unsigned FIFO_WIDTH     = 16,
  parameter int unsigned DELAY_PRESCALE = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                pause,
  bpsm_sequencer_if.master    bus,
  output logic [BP_PINS-1:0]  io_out,
  output logic                la_active,
  output logic                active,
  output logic                error
);

  localparam int unsigned CNT_W = 8 + $clog2(DELAY_PRESCALE + 1);

  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_PIN = 8'h81;
  localparam logic [7:0] OP_SPI = 8'h08;
  localparam logic [7:0] OP_DLY = 8'h84;
  localparam logic [7:0] OP_LAS = 8'hFE;
  localparam logic [7:0] OP_LAC = 8'hFF;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    EXEC     = 3'd1,
    SPI_WAIT = 3'd2,
    PUSH     = 3'd3,
    DELAY    = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [15:0]      cmd_q;
  logic [CNT_W-1:0] cnt_q;
  logic             pause_q;
  logic [7:0]       opcode, operand;

  logic cmd_load, pin_load, la_set, la_clr, spi_fire, res_load, dly_load, err_set;

  assign opcode  = cmd_q[15:8];
  assign operand = cmd_q[7:0];

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (bus.cmd_nempty && !pause) state_d = EXEC;
      EXEC: begin
        case (opcode)
          OP_SPI:  if (!bus.spi_busy) state_d = SPI_WAIT;
          OP_DLY:  state_d = (operand == 8'd0) ? IDLE : DELAY;
          default: state_d = IDLE;
        endcase
      end
      SPI_WAIT: if (bus.spi_done) state_d = PUSH;
      PUSH:     if (!bus.res_full) state_d = IDLE;
      DELAY:    if (cnt_q <= CNT_W'(1)) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Output decode: the two FIFO strobes are combinational so they can never
  // contradict the current FIFO status; everything else is a load enable.
  always_comb begin
    bus.cmd_pop  = 1'b0;
    bus.res_push = 1'b0;
    cmd_load     = 1'b0;
    pin_load     = 1'b0;
    la_set       = 1'b0;
    la_clr       = 1'b0;
    spi_fire     = 1'b0;
    res_load     = 1'b0;
    dly_load     = 1'b0;
    err_set      = 1'b0;
    unique case (state_q)
      IDLE: begin
        // reset gating keeps the pop quiet while reset is held low
        if (reset && bus.cmd_nempty && !pause) begin
          bus.cmd_pop = 1'b1;
          cmd_load    = 1'b1;
        end
      end
      EXEC: begin
        case (opcode)
          OP_NOP:  ;
          OP_PIN:  pin_load = 1'b1;
          OP_LAS:  la_set   = 1'b1;
          OP_LAC:  la_clr   = 1'b1;
          OP_SPI:  spi_fire = !bus.spi_busy;
          OP_DLY:  dly_load = (operand != 8'd0);
          default: err_set  = 1'b1;
        endcase
      end
      SPI_WAIT: res_load     = bus.spi_done;
      PUSH:     bus.res_push = !bus.res_full;
      default:  ;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cmd_q         <= 16'h0;
      io_out        <= '0;
      la_active     <= 1'b0;
      bus.spi_data  <= 8'h0;
      bus.spi_start <= 1'b0;
      bus.res_data  <= '0;
      cnt_q         <= '0;
      error         <= 1'b0;
      pause_q       <= 1'b0;
      active        <= 1'b0;
    end else begin
      pause_q       <= pause;
      active        <= (state_d != IDLE);
      bus.spi_start <= spi_fire;
      if (cmd_load) cmd_q <= bus.cmd_data[15:0];
      if (pin_load) io_out <= operand[BP_PINS-1:0];
      if (la_set)   la_active <= 1'b1;
      else if (la_clr) la_active <= 1'b0;
      if (spi_fire) bus.spi_data <= operand;
      if (res_load) bus.res_data <= FIFO_WIDTH'({OP_SPI, bus.spi_rx});
      if (dly_load) cnt_q <= CNT_W'(operand) * CNT_W'(DELAY_PRESCALE);
      else if (state_q == DELAY) cnt_q <= cnt_q - CNT_W'(1);
      // a new unknown opcode outranks a simultaneous pause-edge clear
      if (err_set) error <= 1'b1;
      else if (pause && !pause_q) error <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bpsm_sequencer.sv
`timescale 1ns/1ps
module tb_bpsm_sequencer;
  localparam int unsigned PINS = 5;
  localparam int unsigned FW   = 16;
  localparam int unsigned PRE  = 1;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic pause = 1'b0;
  logic [PINS-1:0] io_out;
  logic la_active, active, error;

  bpsm_sequencer_if #(.FIFO_WIDTH(FW)) bus ();

  bpsm_sequencer #(.BP_PINS(PINS), .FIFO_WIDTH(FW), .DELAY_PRESCALE(PRE)) dut (
    .clock(clock), .reset(reset), .pause(pause), .bus(bus),
    .io_out(io_out), .la_active(la_active), .active(active), .error(error)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int ncyc  = 0;

  // environment models
  logic [15:0] fifo[$];
  int   spi_cnt = 0;
  int   spi_lat_fixed = 3;
  bit   rx_force = 1'b1;
  logic [7:0] rx_val = 8'h55;
  bit   full_force = 1'b0, full_rand = 1'b0, busy_rand = 1'b0;

  // logs
  logic [7:0]  start_log[$];
  logic [15:0] push_log[$];
  logic [7:0]  rx_hist[$];
  int          pop_log[$];

  // samples taken at the falling edge of the last cycle
  logic s_pop, s_start, s_push, s_active, s_la, s_err;
  logic [PINS-1:0] s_io;

  typedef struct {
    logic [15:0]     cmd;
    int              act;
    logic [PINS-1:0] io;
    logic            la;
    logic            err;
  } vec_t;
  vec_t vt[12];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic drive_inputs();
    bus.cmd_nempty = (fifo.size() > 0);
    bus.cmd_data   = (fifo.size() > 0) ? fifo[0] : 16'h0;
  endtask

  task automatic cyc();
    @(negedge clock);
    ncyc++;
    s_pop = bus.cmd_pop; s_start = bus.spi_start; s_push = bus.res_push;
    s_active = active; s_la = la_active; s_err = error; s_io = io_out;
    if (s_pop) begin
      check("pop_nempty", 32'(bus.cmd_nempty), 32'd1);
      pop_log.push_back(ncyc);
    end
    if (s_start) start_log.push_back(bus.spi_data);
    if (s_push) begin
      check("push_notfull", 32'(bus.res_full), 32'd0);
      push_log.push_back(bus.res_data);
    end
    @(posedge clock); #1;
    if (s_pop && fifo.size() > 0) void'(fifo.pop_front());
    bus.spi_done = 1'b0;
    if (s_start) spi_cnt = (spi_lat_fixed > 0) ? spi_lat_fixed : int'($urandom_range(1, 5));
    if (spi_cnt > 0) begin
      spi_cnt--;
      if (spi_cnt == 0) begin
        bus.spi_done = 1'b1;
        bus.spi_rx   = rx_force ? rx_val : 8'($urandom);
        rx_hist.push_back(bus.spi_rx);
      end
    end
    bus.spi_busy = (spi_cnt > 0) || (busy_rand && $urandom_range(0, 3) == 0);
    bus.res_full = full_force || (full_rand && $urandom_range(0, 2) == 0);
    drive_inputs();
  endtask

  task automatic wait_pops(input int n, input int budget, input string name);
    for (int i = 0; i < budget && pop_log.size() < n; i++) cyc();
    check(name, 32'(pop_log.size()), 32'(n));
  endtask

  task automatic run_one(input logic [15:0] word, output int act);
    bit got;
    fifo.push_back(word);
    drive_inputs();
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      cyc();
      if (s_pop) got = 1'b1;
    end
    check("vec_pop", 32'(got), 32'd1);
    act = 0;
    for (int i = 0; i < 3000; i++) begin
      cyc();
      if (!s_active) break;
      act++;
    end
  endtask

  task automatic clear_logs();
    start_log.delete(); push_log.delete(); rx_hist.delete(); pop_log.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int act;
    int n_cmd;
    logic [15:0] cmds[$];
    int dur[$];
    logic [7:0] exp_spi[$];
    logic [PINS-1:0] exp_io;
    logic exp_la, exp_err;
    logic [7:0] illegal_ops[6];
    logic [7:0] opnd;

    bus.cmd_data = '0; bus.cmd_nempty = 1'b0; bus.spi_busy = 1'b0;
    bus.spi_done = 1'b0; bus.spi_rx = 8'h0; bus.res_full = 1'b0;

    // reset state
    #3;
    check("rst_io", 32'(io_out), 32'd0);
    check("rst_la", 32'(la_active), 32'd0);
    check("rst_err", 32'(error), 32'd0);
    check("rst_active", 32'(active), 32'd0);
    check("rst_spi_start", 32'(bus.spi_start), 32'd0);
    check("rst_spi_data", 32'(bus.spi_data), 32'd0);
    check("rst_res_data", 32'(bus.res_data), 32'd0);
    check("rst_res_push", 32'(bus.res_push), 32'd0);
    @(posedge clock); #1;
    reset = 1'b1;
    cyc();

    // single-command vectors; expected state is cumulative
    vt[0]  = '{16'h8115, 1,       5'h15, 1'b0, 1'b0};
    vt[1]  = '{16'h0000, 1,       5'h15, 1'b0, 1'b0};
    vt[2]  = '{16'hFE00, 1,       5'h15, 1'b1, 1'b0};
    vt[3]  = '{16'hFE00, 1,       5'h15, 1'b1, 1'b0};
    vt[4]  = '{16'h8400, 1,       5'h15, 1'b1, 1'b0};
    vt[5]  = '{16'h8403, 1+3*PRE, 5'h15, 1'b1, 1'b0};
    vt[6]  = '{16'h840F, 1+15*PRE,5'h15, 1'b1, 1'b0};
    vt[7]  = '{16'hFF00, 1,       5'h15, 1'b0, 1'b0};
    vt[8]  = '{16'h81EA, 1,       5'h0A, 1'b0, 1'b0};
    vt[9]  = '{16'h1234, 1,       5'h0A, 1'b0, 1'b1};
    vt[10] = '{16'h0000, 1,       5'h0A, 1'b0, 1'b1};
    vt[11] = '{16'h8100, 1,       5'h00, 1'b0, 1'b1};
    for (int v = 0; v < 12; v++) begin
      run_one(vt[v].cmd, act);
      check($sformatf("vec%0d_active_cycles", v), 32'(act), 32'(vt[v].act));
      check($sformatf("vec%0d_io", v), 32'(s_io), 32'(vt[v].io));
      check($sformatf("vec%0d_la", v), 32'(s_la), 32'(vt[v].la));
      check($sformatf("vec%0d_err", v), 32'(s_err), 32'(vt[v].err));
    end

    // back-to-back pin writes
    clear_logs();
    fifo.push_back(16'h81FF); fifo.push_back(16'h8100); drive_inputs();
    wait_pops(1, 20, "b2b_first_pop");
    cyc(); cyc();
    check("b2b_io_1f", 32'(s_io), 32'h1F);
    check("b2b_second_pop", 32'(s_pop), 32'd1);
    cyc(); cyc();
    check("b2b_io_00", 32'(s_io), 32'h00);
    cyc(); cyc(); cyc();
    check("b2b_pop_count", 32'(pop_log.size()), 32'd2);

    // delay then immediate next fetch
    clear_logs();
    fifo.push_back(16'h840F); fifo.push_back(16'h0000); drive_inputs();
    wait_pops(2, 100, "dly_pops");
    check("dly_pop_gap", 32'(pop_log[1] - pop_log[0]), 32'(2 + 15 * PRE));
    cyc(); cyc();

    // SPI transfer with fixed 3-cycle engine latency
    clear_logs();
    rx_force = 1'b1; rx_val = 8'h55; spi_lat_fixed = 3;
    fifo.push_back(16'h08AA); drive_inputs();
    for (int i = 0; i < 20; i++) cyc();
    check("spi_start_count", 32'(start_log.size()), 32'd1);
    check("spi_data", 32'(start_log[0]), 32'hAA);
    check("spi_push_count", 32'(push_log.size()), 32'd1);
    check("spi_res_data", 32'(push_log[0]), 32'h0855);

    // pause blocks fetch; result FIFO full holds the push
    clear_logs();
    pause = 1'b1;
    fifo.push_back(16'h0000); fifo.push_back(16'h083C); drive_inputs();
    for (int i = 0; i < 5; i++) cyc();
    check("pause_no_pop", 32'(pop_log.size()), 32'd0);
    pause = 1'b0; rx_val = 8'h3C; full_force = 1'b1; bus.res_full = 1'b1;
    cyc();
    check("pause_fall_pop", 32'(s_pop), 32'd1);
    for (int i = 0; i < 14; i++) cyc();
    check("full_no_push", 32'(push_log.size()), 32'd0);
    check("full_held_active", 32'(s_active), 32'd1);
    full_force = 1'b0; bus.res_full = 1'b0;
    cyc();
    check("full_release_push", 32'(s_push), 32'd1);
    check("full_res_data", 32'(push_log[0]), 32'h083C);
    cyc(); cyc();

    // LA start, illegal opcode, LA stop, then a pause pulse clears error
    run_one(16'hFE00, act);
    check("la_on", 32'(s_la), 32'd1);
    run_one(16'h1234, act);
    check("illegal_err", 32'(s_err), 32'd1);
    run_one(16'hFF00, act);
    check("la_off", 32'(s_la), 32'd0);
    check("err_sticky", 32'(s_err), 32'd1);
    pause = 1'b1; cyc(); pause = 1'b0; cyc();
    check("pause_clears_err", 32'(s_err), 32'd0);

    // reset during DELAY
    clear_logs();
    fifo.push_back(16'hFE00); fifo.push_back(16'h8115);
    fifo.push_back(16'h8420); fifo.push_back(16'h8106); drive_inputs();
    wait_pops(3, 40, "rstdly_pops");
    for (int i = 0; i < 5; i++) cyc();
    check("rstdly_in_delay", 32'(s_active), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("rstdly_io", 32'(io_out), 32'd0);
    check("rstdly_la", 32'(la_active), 32'd0);
    check("rstdly_active", 32'(active), 32'd0);
    check("rstdly_pop", 32'(bus.cmd_pop), 32'd0);
    pop_log.delete();
    cyc(); cyc();
    check("rstdly_no_pop_in_reset", 32'(pop_log.size()), 32'd0);
    reset = 1'b1;
    wait_pops(1, 20, "rstdly_resume_pop");
    for (int i = 0; i < 4; i++) cyc();
    check("rstdly_resume_io", 32'(s_io), 32'h06);
    check("rstdly_fifo_drained", 32'(fifo.size()), 32'd0);

    // randomized stream against a command-level model
    reset = 1'b0; #3; reset = 1'b1;
    cyc();
    clear_logs();
    illegal_ops[0] = 8'h01; illegal_ops[1] = 8'h80; illegal_ops[2] = 8'h09;
    illegal_ops[3] = 8'h82; illegal_ops[4] = 8'hFD; illegal_ops[5] = 8'h12;
    exp_io = '0; exp_la = 1'b0; exp_err = 1'b0;
    n_cmd = 60;
    for (int i = 0; i < n_cmd; i++) begin
      opnd = 8'($urandom);
      case ($urandom_range(0, 5))
        0: begin cmds.push_back(16'h0000); dur.push_back(2); end
        1: begin cmds.push_back({8'h81, opnd}); dur.push_back(2); exp_io = opnd[PINS-1:0]; end
        2: begin
          exp_la = opnd[0];
          cmds.push_back(opnd[0] ? 16'hFE00 : 16'hFF00); dur.push_back(2);
        end
        3: begin
          opnd = 8'($urandom_range(0, 6));
          cmds.push_back({8'h84, opnd}); dur.push_back(2 + int'(opnd) * PRE);
        end
        4: begin cmds.push_back({8'h08, opnd}); dur.push_back(0); exp_spi.push_back(opnd); end
        default: begin
          cmds.push_back({illegal_ops[$urandom_range(0, 5)], opnd}); dur.push_back(2);
          exp_err = 1'b1;
        end
      endcase
    end
    rx_force = 1'b0; spi_lat_fixed = 0; full_rand = 1'b1; busy_rand = 1'b1;
    foreach (cmds[i]) fifo.push_back(cmds[i]);
    drive_inputs();
    for (int i = 0; i < 20000; i++) begin
      cyc();
      if (pop_log.size() == n_cmd && !s_active && !s_pop && spi_cnt == 0) break;
    end
    full_rand = 1'b0; busy_rand = 1'b0;
    check("rnd_pop_count", 32'(pop_log.size()), 32'(n_cmd));
    for (int i = 0; i < n_cmd - 1 && i + 1 < pop_log.size(); i++)
      if (dur[i] > 0)
        check($sformatf("rnd_gap%0d", i), 32'(pop_log[i+1] - pop_log[i]), 32'(dur[i]));
    check("rnd_start_count", 32'(start_log.size()), 32'(exp_spi.size()));
    for (int i = 0; i < exp_spi.size() && i < start_log.size(); i++)
      check($sformatf("rnd_spi_data%0d", i), 32'(start_log[i]), 32'(exp_spi[i]));
    check("rnd_push_count", 32'(push_log.size()), 32'(rx_hist.size()));
    for (int i = 0; i < rx_hist.size() && i < push_log.size(); i++)
      check($sformatf("rnd_res%0d", i), 32'(push_log[i]), 32'({8'h08, rx_hist[i]}));
    check("rnd_io", 32'(io_out), 32'(exp_io));
    check("rnd_la", 32'(la_active), 32'(exp_la));
    check("rnd_err", 32'(error), 32'(exp_err));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
